// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared constants and helpers for the pipeline hazard/forwarding controller.
// Pure declarations: no timing.
// No flow control of its own.
package pipeline_hazard_unit_pkg;

  // Operand source encodings for fwd_a_sel / fwd_b_sel.
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // One bit per pipeline stage, IF first.
  typedef struct packed {
    logic if_s;
    logic id_s;
    logic exe_s;
    logic mem_s;
    logic wb_s;
  } stage_vec_t;

  // Youngest usable producer wins: EXE, then MEM, then WB, else register file.
  function automatic logic [1:0] fwd_pick(input logic use_exe, input logic use_mem,
                                          input logic use_wb);
    if (use_exe)      return FWD_EXE;
    else if (use_mem) return FWD_MEM;
    else if (use_wb)  return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// Per-operand RAW detection against EXE/MEM/WB producers and source selection.
// Purely combinational, zero latency.
// No backpressure; the hit flags let the parent decide on interlocks.
module pipeline_hazard_unit_fwd_select
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  used,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [REG_ADDR_W-1:0] regw_addr_exe,
  input  logic [REG_ADDR_W-1:0] regw_addr_mem,
  input  logic [REG_ADDR_W-1:0] regw_addr_wb,
  input  logic                  wb_wen_exe,
  input  logic                  wb_wen_mem,
  input  logic                  wb_wen_wb,
  input  logic                  mem_ren_exe,
  output logic [1:0]            sel,
  output logic                  hit_exe,
  output logic                  hit_mem
);

  logic live;
  logic hit_wb;

  // Register 0 is hardwired, so it never takes part in a dependency.
  assign live    = used && (addr != '0);
  assign hit_exe = live && wb_wen_exe && (regw_addr_exe == addr);
  assign hit_mem = live && wb_wen_mem && (regw_addr_mem == addr);
  assign hit_wb  = live && wb_wen_wb  && (regw_addr_wb  == addr);

  // A load still in EXE has no data yet, so fall through to older producers.
  assign sel = fwd_pick(hit_exe && !mem_ren_exe, hit_mem, hit_wb);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: forwarding, load-use, branch bubbles, freeze, debug step.
// Stage controls are combinational from inputs and state; bubble counter and statistics update at posedge clk.
// mem_busy or a held debug pause drops every stage enable and freezes all internal state.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int FWD_EN         = 1,
  parameter int PRED_NOT_TAKEN = 0,
  parameter int BRANCH_BUBBLES = 3,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  debug_en,
  input  logic                  debug_step,
  input  logic                  mem_busy,
  input  logic [REG_ADDR_W-1:0] rs_addr_id,
  input  logic [REG_ADDR_W-1:0] rt_addr_id,
  input  logic                  rs_used_id,
  input  logic                  rt_used_id,
  input  logic                  is_branch_id,
  input  logic                  branch_taken,
  input  logic [REG_ADDR_W-1:0] regw_addr_exe,
  input  logic [REG_ADDR_W-1:0] regw_addr_mem,
  input  logic [REG_ADDR_W-1:0] regw_addr_wb,
  input  logic                  wb_wen_exe,
  input  logic                  wb_wen_mem,
  input  logic                  wb_wen_wb,
  input  logic                  mem_ren_exe,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  if_rst,
  output logic                  id_rst,
  output logic                  exe_rst,
  output logic                  mem_rst,
  output logic                  wb_rst,
  output logic                  if_en,
  output logic                  id_en,
  output logic                  exe_en,
  output logic                  mem_en,
  output logic                  wb_en,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
);

  localparam logic [2:0] BUB_LOAD = 3'(BRANCH_BUBBLES - 1);

  logic             step_prev_q;
  logic [2:0]       bub_q, bub_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  logic [1:0] sel_a, sel_b;
  logic       hit_exe_a, hit_mem_a, hit_exe_b, hit_mem_b;
  logic       reg_stall, frozen, taken_flush, bub_flush;
  logic       stall_case, flush_case, bub_case;
  stage_vec_t rst_v, en_v;

  pipeline_hazard_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .used(rs_used_id), .addr(rs_addr_id),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
    .mem_ren_exe(mem_ren_exe), .sel(sel_a), .hit_exe(hit_exe_a), .hit_mem(hit_mem_a)
  );

  pipeline_hazard_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .used(rt_used_id), .addr(rt_addr_id),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
    .mem_ren_exe(mem_ren_exe), .sel(sel_b), .hit_exe(hit_exe_b), .hit_mem(hit_mem_b)
  );

  // Without forwarding, any producer still in EXE or MEM must drain; the RF writes before it is read, so WB is safe.
  assign reg_stall = (FWD_EN != 0) ? ((hit_exe_a || hit_exe_b) && mem_ren_exe)
                                   : (hit_exe_a || hit_mem_a || hit_exe_b || hit_mem_b);

  // A debug pause is lifted for exactly the cycle following a rising step edge.
  assign frozen      = (debug_en && !(debug_step && !step_prev_q)) || mem_busy;
  assign taken_flush = (PRED_NOT_TAKEN != 0) && branch_taken;
  assign bub_flush   = (PRED_NOT_TAKEN == 0) && (is_branch_id || (bub_q != 3'd0));

  assign fwd_a_sel = (!rst_n || FWD_EN == 0) ? FWD_RF : sel_a;
  assign fwd_b_sel = (!rst_n || FWD_EN == 0) ? FWD_RF : sel_b;

  // Prioritised stage control: freeze, taken-branch flush, interlock, branch bubble; reset overrides all.
  always_comb begin
    rst_v      = '0;
    en_v       = '1;
    stall_case = 1'b0;
    flush_case = 1'b0;
    bub_case   = 1'b0;
    if (frozen) begin
      en_v = '0;
    end else if (taken_flush) begin
      rst_v.id_s  = 1'b1;
      rst_v.exe_s = 1'b1;
      flush_case  = 1'b1;
    end else if (reg_stall) begin
      en_v.if_s   = 1'b0;
      en_v.id_s   = 1'b0;
      rst_v.exe_s = 1'b1;
      stall_case  = 1'b1;
    end else if (bub_flush) begin
      rst_v.id_s = 1'b1;
      flush_case = 1'b1;
      bub_case   = 1'b1;
    end
    if (!rst_n) begin
      rst_v = '1;
      en_v  = '1;
    end
  end

  assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_v;
  assign {if_en,  id_en,  exe_en,  mem_en,  wb_en}  = en_v;

  // Branch bubble countdown: a new branch arms it only once it actually reaches the bubble case.
  always_comb begin
    bub_d = bub_q;
    if (!frozen) begin
      if (bub_case && is_branch_id && (bub_q == 3'd0)) bub_d = BUB_LOAD;
      else if (bub_q != 3'd0)                          bub_d = bub_q - 3'd1;
    end
  end

  // Saturating statistics; they only see unfrozen cycles because the cases above exclude freezes.
  always_comb begin
    stall_d = (stall_case && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flush_case && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_prev_q <= 1'b0;
      bub_q       <= 3'd0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      step_prev_q <= debug_step;
      bub_q       <= bub_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, debug_en, debug_step, mem_busy;
  logic [4:0] rs_addr_id, rt_addr_id, regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic       rs_used_id, rt_used_id, is_branch_id, branch_taken;
  logic       wb_wen_exe, wb_wen_mem, wb_wen_wb, mem_ren_exe;

  // Three configurations: 0 = forwarding/bubbles(3), 1 = no forwarding/bubbles(2)/4-bit counters, 2 = forwarding/predict-not-taken
  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic [4:0]  rs_o [3];
  logic [4:0]  en_o [3];
  logic [31:0] sc [3];
  logic [31:0] fc [3];
  logic [3:0]  sc1, fc1;
  assign sc[1] = {28'd0, sc1};
  assign fc[1] = {28'd0, fc1};

  pipeline_hazard_unit #(.FWD_EN(1), .PRED_NOT_TAKEN(0), .BRANCH_BUBBLES(3), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step), .mem_busy(mem_busy),
    .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .is_branch_id(is_branch_id), .branch_taken(branch_taken),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb), .mem_ren_exe(mem_ren_exe),
    .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
    .if_rst(rs_o[0][4]), .id_rst(rs_o[0][3]), .exe_rst(rs_o[0][2]), .mem_rst(rs_o[0][1]), .wb_rst(rs_o[0][0]),
    .if_en(en_o[0][4]), .id_en(en_o[0][3]), .exe_en(en_o[0][2]), .mem_en(en_o[0][1]), .wb_en(en_o[0][0]),
    .stall_cycles(sc[0]), .flush_cycles(fc[0]));

  pipeline_hazard_unit #(.FWD_EN(0), .PRED_NOT_TAKEN(0), .BRANCH_BUBBLES(2), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step), .mem_busy(mem_busy),
    .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .is_branch_id(is_branch_id), .branch_taken(branch_taken),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb), .mem_ren_exe(mem_ren_exe),
    .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
    .if_rst(rs_o[1][4]), .id_rst(rs_o[1][3]), .exe_rst(rs_o[1][2]), .mem_rst(rs_o[1][1]), .wb_rst(rs_o[1][0]),
    .if_en(en_o[1][4]), .id_en(en_o[1][3]), .exe_en(en_o[1][2]), .mem_en(en_o[1][1]), .wb_en(en_o[1][0]),
    .stall_cycles(sc1), .flush_cycles(fc1));

  pipeline_hazard_unit #(.FWD_EN(1), .PRED_NOT_TAKEN(1), .BRANCH_BUBBLES(3), .CNT_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .debug_en(debug_en), .debug_step(debug_step), .mem_busy(mem_busy),
    .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .is_branch_id(is_branch_id), .branch_taken(branch_taken),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb), .mem_ren_exe(mem_ren_exe),
    .fwd_a_sel(fa[2]), .fwd_b_sel(fb[2]),
    .if_rst(rs_o[2][4]), .id_rst(rs_o[2][3]), .exe_rst(rs_o[2][2]), .mem_rst(rs_o[2][1]), .wb_rst(rs_o[2][0]),
    .if_en(en_o[2][4]), .id_en(en_o[2][3]), .exe_en(en_o[2][2]), .mem_en(en_o[2][1]), .wb_en(en_o[2][0]),
    .stall_cycles(sc[2]), .flush_cycles(fc[2]));

  // ---------------- reference model ----------------
  int     cf_fwd [3] = '{1, 0, 1};
  int     cf_pnt [3] = '{0, 0, 1};
  int     cf_bb  [3] = '{3, 2, 3};
  longint cf_max [3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};

  int     m_bub [3];   // bubble cycles still owed after the current one
  bit     m_sp  [3];
  longint m_sc  [3];
  longint m_fc  [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit hit(input bit used, input logic [4:0] a, input bit wen, input logic [4:0] w);
    return used && (a != 5'd0) && wen && (w == a);
  endfunction

  function automatic logic [1:0] ref_sel(input int fwd, input bit used, input logic [4:0] a);
    if (fwd == 0 || !rst_n) return 2'd0;
    if (hit(used, a, wb_wen_exe, regw_addr_exe) && !mem_ren_exe) return 2'd1;
    if (hit(used, a, wb_wen_mem, regw_addr_mem)) return 2'd2;
    if (hit(used, a, wb_wen_wb, regw_addr_wb)) return 2'd3;
    return 2'd0;
  endfunction

  // kind: 0 normal, 1 frozen, 3 taken flush, 4 interlock, 5 branch bubble
  task automatic ref_eval(input int k, output logic [1:0] efa, output logic [1:0] efb,
                          output logic [4:0] ers, output logic [4:0] een, output int kind);
    bit ea, ma, eb, mb, stall;
    ea = hit(rs_used_id, rs_addr_id, wb_wen_exe, regw_addr_exe);
    ma = hit(rs_used_id, rs_addr_id, wb_wen_mem, regw_addr_mem);
    eb = hit(rt_used_id, rt_addr_id, wb_wen_exe, regw_addr_exe);
    mb = hit(rt_used_id, rt_addr_id, wb_wen_mem, regw_addr_mem);
    stall = (cf_fwd[k] != 0) ? ((ea || eb) && mem_ren_exe) : (ea || ma || eb || mb);
    efa = ref_sel(cf_fwd[k], rs_used_id, rs_addr_id);
    efb = ref_sel(cf_fwd[k], rt_used_id, rt_addr_id);
    ers = 5'b00000; een = 5'b11111; kind = 0;
    if ((debug_en && !(debug_step && !m_sp[k])) || mem_busy) begin een = 5'b00000; kind = 1; end
    else if (cf_pnt[k] != 0 && branch_taken) begin ers = 5'b01100; kind = 3; end
    else if (stall) begin een = 5'b00111; ers = 5'b00100; kind = 4; end
    else if (cf_pnt[k] == 0 && (is_branch_id || m_bub[k] > 0)) begin ers = 5'b01000; kind = 5; end
    if (!rst_n) begin ers = 5'b11111; een = 5'b11111; end
  endtask

  task automatic sample();
    logic [1:0] efa, efb; logic [4:0] ers, een; int kind;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ref_eval(k, efa, efb, ers, een, kind);
      chk($sformatf("d%0d_fwd_a", k), 32'(fa[k]), 32'(efa));
      chk($sformatf("d%0d_fwd_b", k), 32'(fb[k]), 32'(efb));
      chk($sformatf("d%0d_rst", k), 32'(rs_o[k]), 32'(ers));
      chk($sformatf("d%0d_en", k), 32'(en_o[k]), 32'(een));
      chk($sformatf("d%0d_stall_cycles", k), sc[k], 32'(m_sc[k]));
      chk($sformatf("d%0d_flush_cycles", k), fc[k], 32'(m_fc[k]));
    end
  endtask

  task automatic adv();
    logic [1:0] efa, efb; logic [4:0] ers, een; int kind;
    for (int k = 0; k < 3; k++) begin
      ref_eval(k, efa, efb, ers, een, kind);
      if (!rst_n) begin
        m_bub[k] = 0; m_sp[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        m_sp[k] = debug_step;
        if (kind == 4 && m_sc[k] < cf_max[k]) m_sc[k]++;
        if ((kind == 3 || kind == 5) && m_fc[k] < cf_max[k]) m_fc[k]++;
        if (kind != 1) begin
          if (kind == 5 && is_branch_id && m_bub[k] == 0) m_bub[k] = cf_bb[k] - 1;
          else if (m_bub[k] > 0) m_bub[k]--;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  task automatic idle();
    rst_n = 1; debug_en = 0; debug_step = 0; mem_busy = 0;
    rs_addr_id = 0; rt_addr_id = 0; rs_used_id = 0; rt_used_id = 0;
    is_branch_id = 0; branch_taken = 0;
    regw_addr_exe = 0; regw_addr_mem = 0; regw_addr_wb = 0;
    wb_wen_exe = 0; wb_wen_mem = 0; wb_wen_wb = 0; mem_ren_exe = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    idle();
  endtask

  // Forwarding vectors: ID operands vs producers; xa/xb = config0 selects, st0/st1 = config0/config1 interlock
  typedef struct {
    int rs, rt, rsu, rtu, we, wm, ww, ee, em, ew, ren, xa, xb, st0, st1;
  } vec_t;
  vec_t vecs [11];

  initial begin
    foreach (m_bub[k]) begin m_bub[k] = 0; m_sp[k] = 0; m_sc[k] = 0; m_fc[k] = 0; end
    vecs[0]  = '{3, 0, 1, 0, 3, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
    vecs[1]  = '{0, 4, 0, 1, 4, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    vecs[2]  = '{5, 0, 1, 0, 0, 5, 0, 0, 1, 0, 0, 2, 0, 0, 1};
    vecs[3]  = '{6, 0, 1, 0, 0, 0, 6, 0, 0, 1, 0, 3, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    vecs[5]  = '{7, 0, 1, 0, 7, 7, 7, 1, 1, 1, 0, 1, 0, 0, 1};
    vecs[6]  = '{7, 0, 1, 0, 7, 7, 7, 1, 1, 1, 1, 2, 0, 1, 1};
    vecs[7]  = '{7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{2, 2, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0, 1};
    vecs[9]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 3, 0, 0, 0};
    vecs[10] = '{0, 9, 0, 1, 9, 0, 9, 1, 0, 1, 1, 0, 3, 1, 1};

    idle();
    rst_n = 0;
    sample();
    chk("reset_rst_all", 32'(rs_o[0]), 32'h1f);
    chk("reset_en_all", 32'(en_o[0]), 32'h1f);
    chk("reset_stall_cnt", sc[0], 32'd0);
    adv();
    idle();

    // table-driven forwarding / interlock
    foreach (vecs[i]) begin
      idle();
      rs_addr_id = 5'(vecs[i].rs); rt_addr_id = 5'(vecs[i].rt);
      rs_used_id = vecs[i].rsu[0]; rt_used_id = vecs[i].rtu[0];
      regw_addr_exe = 5'(vecs[i].we); regw_addr_mem = 5'(vecs[i].wm); regw_addr_wb = 5'(vecs[i].ww);
      wb_wen_exe = vecs[i].ee[0]; wb_wen_mem = vecs[i].em[0]; wb_wen_wb = vecs[i].ew[0];
      mem_ren_exe = vecs[i].ren[0];
      sample();
      chk($sformatf("vec%0d_fwd_a", i), 32'(fa[0]), 32'(vecs[i].xa));
      chk($sformatf("vec%0d_fwd_b", i), 32'(fb[0]), 32'(vecs[i].xb));
      chk($sformatf("vec%0d_en_fwd", i), 32'(en_o[0]), vecs[i].st0 != 0 ? 32'h07 : 32'h1f);
      chk($sformatf("vec%0d_en_nofwd", i), 32'(en_o[1]), vecs[i].st1 != 0 ? 32'h07 : 32'h1f);
      chk($sformatf("vec%0d_fwd_a_nofwd", i), 32'(fa[1]), 32'd0);
      adv();
    end

    // load-use: one interlock cycle, then the load forwards from MEM
    idle();
    rt_used_id = 1; rt_addr_id = 4; regw_addr_exe = 4; wb_wen_exe = 1; mem_ren_exe = 1;
    sample();
    chk("loaduse_en", 32'(en_o[0]), 32'h07);
    chk("loaduse_rst", 32'(rs_o[0]), 32'h04);
    adv();
    wb_wen_exe = 0; mem_ren_exe = 0; regw_addr_exe = 0; regw_addr_mem = 4; wb_wen_mem = 1;
    sample();
    chk("loaduse_next_fwd_b", 32'(fb[0]), 32'd2);
    chk("loaduse_next_en", 32'(en_o[0]), 32'h1f);
    adv();

    // branch bubbles; reset also clears accumulated statistics
    do_reset();
    is_branch_id = 1;
    sample();
    chk("post_reset_stall_cnt", sc[0], 32'd0);
    chk("post_reset_flush_cnt", fc[0], 32'd0);
    chk("br_id_rst_0", 32'(rs_o[0][3]), 32'd1);
    adv();
    is_branch_id = 0;
    for (int j = 1; j < 4; j++) begin
      sample();
      chk($sformatf("br_id_rst_%0d", j), 32'(rs_o[0][3]), (j < 3) ? 32'd1 : 32'd0);
      adv();
    end
    sample();
    chk("br_flush_cnt_bb3", fc[0], 32'd3);
    chk("br_flush_cnt_bb2", fc[1], 32'd2);
    chk("br_flush_cnt_pnt", fc[2], 32'd0);
    adv();

    // memory busy in the middle of a bubble run freezes everything
    do_reset();
    is_branch_id = 1;
    tick();
    is_branch_id = 0; mem_busy = 1;
    for (int j = 0; j < 4; j++) begin
      sample();
      chk($sformatf("busy_en_%0d", j), 32'(en_o[0]), 32'd0);
      chk($sformatf("busy_id_rst_%0d", j), 32'(rs_o[0][3]), 32'd0);
      adv();
    end
    mem_busy = 0;
    for (int j = 0; j < 3; j++) begin
      sample();
      chk($sformatf("busy_resume_id_rst_%0d", j), 32'(rs_o[0][3]), (j < 2) ? 32'd1 : 32'd0);
      adv();
    end
    sample();
    chk("busy_flush_cnt", fc[0], 32'd3);
    adv();

    // debug single-step: one rising edge gives exactly one advancing cycle
    idle();
    debug_en = 1;
    sample(); chk("dbg_hold_en", 32'(en_o[0]), 32'd0); adv();
    debug_step = 1;
    sample(); chk("dbg_step_en", 32'(en_o[0]), 32'h1f); adv();
    sample(); chk("dbg_step_held_en", 32'(en_o[0]), 32'd0); adv();
    debug_step = 0;
    sample(); chk("dbg_step_low_en", 32'(en_o[0]), 32'd0); adv();
    idle();

    // predict-not-taken: taken flush beats load-use; untaken branch costs nothing
    branch_taken = 1; rt_used_id = 1; rt_addr_id = 4; regw_addr_exe = 4; wb_wen_exe = 1; mem_ren_exe = 1;
    sample();
    chk("pnt_taken_rst", 32'(rs_o[2]), 32'h0c);
    chk("pnt_taken_en", 32'(en_o[2]), 32'h1f);
    adv();
    idle();
    is_branch_id = 1;
    sample();
    chk("pnt_not_taken_rst", 32'(rs_o[2]), 32'd0);
    adv();
    idle();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n         = ($urandom_range(0, 63) != 0);
      debug_en      = ($urandom_range(0, 15) == 0);
      debug_step    = $urandom_range(0, 1) == 1;
      mem_busy      = ($urandom_range(0, 6) == 0);
      rs_addr_id    = 5'($urandom_range(0, 3));
      rt_addr_id    = 5'($urandom_range(0, 3));
      rs_used_id    = $urandom_range(0, 1) == 1;
      rt_used_id    = $urandom_range(0, 1) == 1;
      is_branch_id  = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      regw_addr_exe = 5'($urandom_range(0, 3));
      regw_addr_mem = 5'($urandom_range(0, 3));
      regw_addr_wb  = 5'($urandom_range(0, 3));
      wb_wen_exe    = $urandom_range(0, 1) == 1;
      wb_wen_mem    = $urandom_range(0, 1) == 1;
      wb_wen_wb     = $urandom_range(0, 1) == 1;
      mem_ren_exe   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
